// File: rtl/sub_diff_window.sv
// sub_diff_window: windowed statistics over the signed 9-bit difference stream
// produced by the upstream subtractor. Collects WIN samples, then holds the
// saturated total, min, max, negative count and overflow flag until accepted.
module sub_diff_window #(
  parameter int WIN   = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_sum,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [8:0]       out_min,
  output logic [8:0]       out_max,
  output logic [7:0]       out_neg_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Index of the sample that completes a window.
  localparam logic [7:0] LAST_IDX = 8'(WIN - 1);

  // Saturation limits of the signed total.
  localparam logic [ACC_W-1:0] TOT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] TOT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [8:0]       min_q, min_d;
  logic [8:0]       max_q, max_d;
  logic [7:0]       neg_cnt_q, neg_cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   sample_ext;
  logic [ACC_W:0]   sum_ext;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;

  assign accept = in_valid & in_ready_q & ~in_clear;

  // Widened add: the total and the sample are both sign-extended by one bit so
  // the true sum is always representable, and the top two bits expose overflow.
  assign sample_ext = {{(ACC_W - 8){in_sum[8]}}, in_sum};
  assign sum_ext    = {total_q[ACC_W-1], total_q} + sample_ext;
  assign sum_ovf    = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
  assign sum_sat    = !sum_ovf          ? sum_ext[ACC_W-1:0] :
                      sum_ext[ACC_W]    ? TOT_MIN : TOT_MAX;

  // Next-state and result-register computation; clear beats everything.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    total_d     = total_q;
    min_d       = min_q;
    max_d       = max_q;
    neg_cnt_d   = neg_cnt_q;
    ovf_d       = ovf_q;

    if (in_clear) begin
      state_d     = S_IDLE;
      count_d     = 8'd0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else if (state_q == S_HOLD) begin
      if (out_ready) begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (state_q == S_IDLE) begin
        total_d   = sample_ext[ACC_W-1:0];
        min_d     = in_sum;
        max_d     = in_sum;
        neg_cnt_d = {7'd0, in_sum[8]};
        ovf_d     = 1'b0;
      end else begin
        total_d   = sum_sat;
        ovf_d     = ovf_q | sum_ovf;
        if ($signed(in_sum) < $signed(min_q)) min_d = in_sum;
        if ($signed(in_sum) > $signed(max_q)) max_d = in_sum;
        neg_cnt_d = neg_cnt_q + {7'd0, in_sum[8]};
      end

      if (count_q == LAST_IDX) begin
        // Window complete: freeze results and stop taking samples.
        state_d     = S_HOLD;
        count_d     = 8'd0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
      end else begin
        state_d = S_ACCUM;
        count_d = count_q + 8'd1;
      end
    end
  end

  // State and result registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      total_q     <= '0;
      min_q       <= 9'd0;
      max_q       <= 9'd0;
      neg_cnt_q   <= 8'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      total_q     <= total_d;
      min_q       <= min_d;
      max_q       <= max_d;
      neg_cnt_q   <= neg_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_total   = total_q;
  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_neg_cnt = neg_cnt_q;
  assign out_ovf     = ovf_q;

endmodule
